sprite_motion_ctrl: RTL and testbench
=====================================

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter START_Y, default 200: sprite row after reset and in IDLE.
REQ-002 SHALL have parameter TOP_Y, default 0: smallest allowed row.
REQ-003 SHALL have parameter FLOOR_Y, default 440: largest allowed row.
REQ-004 SHALL have parameters JUMP_V (8), GRAVITY (1) and MAX_V (10): jump speed, per-frame speed change and fall speed cap, in rows/frame.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 500000: number of stable clk cycles needed to accept a button level.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port boton, input, 1 bit: raw, asynchronous push-button, active-high.
REQ-009 SHALL have port vsync, input, 1 bit: VGA controller vertical sync, active-low, asynchronous to clk.
REQ-010 SHALL have port currY, output, 32 bits: sprite row for the sprite renderer, zero-extended from 10 bits.
REQ-011 SHALL have port state, output, 2 bits: IDLE=00, RISE=01, FALL=10, GROUND=11.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL pass boton and vsync each through a 2-flop synchronizer before any use.
REQ-014 SHALL change the debounced button level only after the synchronized boton differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch restarts the count.
REQ-015 SHALL set a sticky jump_pending flag on a 0->1 edge of the debounced level; a held button SHALL NOT re-arm the flag.
REQ-016 SHALL pulse frame_tick for one cycle on each 1->0 edge of the synchronized vsync; the row and speed registers SHALL update only in that cycle.
REQ-017 SHALL track speed as a 10-bit unsigned magnitude v; direction is given by state.
REQ-018 SHALL apply the jump rule on a frame_tick with jump_pending=1, in any state: y = max(y-JUMP_V, TOP_Y); v = JUMP_V-GRAVITY, saturating at 0; state = RISE, or FALL if the new v is 0; jump_pending clears in the same cycle.
REQ-019 SHALL, when no jump occurs on the tick, apply the RISE rule: y = y-v; v = v-GRAVITY, saturating at 0; go to FALL when the new v is 0.
REQ-020 SHALL, when no jump occurs on the tick, apply the FALL rule: v = min(v+GRAVITY, MAX_V); y = y+new v.
REQ-021 SHALL, when no jump occurs on the tick, hold y and v in IDLE and in GROUND.
REQ-022 SHALL clamp at the top: if y-v < TOP_Y in RISE or on a jump, y = TOP_Y, v = 0, state = FALL.
REQ-023 SHALL clamp at the floor: if y+v >= FLOOR_Y in FALL, y = FLOOR_Y, v = 0, state = GROUND.
REQ-024 SHALL compute all row arithmetic in 11 bits so that no wrap-around occurs before clamping.
REQ-025 SHALL NOT set jump_pending on a button edge that falls in the same cycle as a jump-rule tick; that edge is taken on the next tick.
REQ-026 SHALL drive currY, state and frame_tick directly from registers.

Reset
REQ-027 SHALL, while reset=0, force y=START_Y (currY=200), v=0, state=IDLE, frame_tick=0, jump_pending=0, debounced level=0, and all synchronizer and counter flops to 0, regardless of clk.
REQ-028 SHALL, after reset is deasserted mid-flight, restart from IDLE with no pending jump; the first frame_tick requires a fresh vsync falling edge.

Verification
REQ-029 SHALL be verified for reset and idle: assert reset=0 with motion in progress, then release -> currY=200, state=00; 5 vsync frames with no button -> currY stays 200.
REQ-030 SHALL be verified for the jump arc, with DEBOUNCE_CYCLES=4 and JUMP_V=3: hold boton 6 cycles, then give 6 ticks -> currY 197, 195, 194, 195, 197, 200; state 01, 01, 10, 10, 10, 10.
REQ-031 SHALL be verified for debounce: a boton pulse of 3 cycles (DEBOUNCE_CYCLES=4), then ticks -> state stays 00 and currY stays 200.
REQ-032 SHALL be verified for the top clamp, with TOP_Y=196 and JUMP_V=3: jump, then tick twice -> currY 197, then 196; state=10, v=0.
REQ-033 SHALL be verified for the floor, with FLOOR_Y=205 and MAX_V=10, falling from 200: ticks give currY 201, 203, then 205 -> state=11; further ticks keep currY at 205.
REQ-034 SHALL be verified for a held button: keep boton high across 10 ticks -> exactly one jump; release and press again -> a second jump on the next tick.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// Vertical motion controller for a jumping sprite: debounced button, vsync frame ticks,
// and a rise/fall/ground state machine that advances the sprite row once per frame.
module sprite_motion_ctrl #(
  parameter int START_Y         = 200,
  parameter int TOP_Y           = 0,
  parameter int FLOOR_Y         = 440,
  parameter int JUMP_V          = 8,
  parameter int GRAVITY         = 1,
  parameter int MAX_V           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boton,
  input  logic        vsync,
  output logic [31:0] currY,
  output logic [1:0]  state,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RISE   = 2'b01,
    S_FALL   = 2'b10,
    S_GROUND = 2'b11
  } state_t;

  localparam int          CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [9:0]  L_START   = 10'(START_Y);
  localparam logic [10:0] L_TOP     = 11'(TOP_Y);
  localparam logic [9:0]  L_TOP10   = 10'(TOP_Y);
  localparam logic [10:0] L_FLOOR   = 11'(FLOOR_Y);
  localparam logic [9:0]  L_FLOOR10 = 10'(FLOOR_Y);
  localparam logic [10:0] L_JV11    = 11'(JUMP_V);
  localparam logic [9:0]  L_JV_NXT  = (JUMP_V > GRAVITY) ? 10'(JUMP_V - GRAVITY) : 10'd0;
  localparam logic [9:0]  L_G10     = 10'(GRAVITY);
  localparam logic [10:0] L_G11     = 11'(GRAVITY);
  localparam logic [9:0]  L_MAX10   = 10'(MAX_V);
  localparam logic [10:0] L_MAX11   = 11'(MAX_V);

  logic          r_btn_s1, r_btn_s2, r_btn_db;
  logic [CW-1:0] r_db_cnt;
  logic          r_vs_s1, r_vs_s2, r_vs_prev;
  logic          r_frame_tick;
  logic          r_jump_pending, r_jump_defer;
  state_t        r_state, w_state_nxt;
  logic [9:0]    r_y, w_y_nxt;
  logic [9:0]    r_v, w_v_nxt;

  logic          w_db_flip, w_db_rise, w_vs_fall, w_jump;
  logic [10:0]   w_y11, w_vinc, w_ysum;
  logic [9:0]    w_vfall, w_vdec;

  // Synchronizers for the two asynchronous inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_btn_s1  <= boton;
      r_btn_s2  <= r_btn_s1;
      r_vs_s1   <= vsync;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
    end
  end

  assign w_db_flip = (r_btn_s2 != r_btn_db) && (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_db_rise = w_db_flip && !r_btn_db;
  assign w_vs_fall = r_vs_prev && !r_vs_s2;
  assign w_jump    = r_frame_tick && r_jump_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_btn_s2 == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (w_db_flip) begin
      r_btn_db <= ~r_btn_db;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // A press landing on a jump tick is parked one cycle so the clear does not swallow it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_tick   <= 1'b0;
      r_jump_pending <= 1'b0;
      r_jump_defer   <= 1'b0;
    end else begin
      r_frame_tick <= w_vs_fall;
      if (w_jump) begin
        r_jump_pending <= 1'b0;
        r_jump_defer   <= w_db_rise | r_jump_defer;
      end else begin
        r_jump_pending <= r_jump_pending | w_db_rise | r_jump_defer;
        r_jump_defer   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_y     <= L_START;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_v     <= w_v_nxt;
    end
  end

  // Row math is done in 11 bits; top tests are rewritten as y < TOP+v to avoid underflow
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_v_nxt     = r_v;
    w_y11       = {1'b0, r_y};
    w_vinc      = {1'b0, r_v} + L_G11;
    w_vfall     = (w_vinc > L_MAX11) ? L_MAX10 : 10'(w_vinc);
    w_ysum      = w_y11 + {1'b0, w_vfall};
    w_vdec      = (r_v > L_G10) ? (r_v - L_G10) : 10'd0;
    if (w_jump) begin
      if (w_y11 < (L_TOP + L_JV11)) begin
        w_y_nxt     = L_TOP10;
        w_v_nxt     = '0;
        w_state_nxt = S_FALL;
      end else begin
        w_y_nxt     = 10'(w_y11 - L_JV11);
        w_v_nxt     = L_JV_NXT;
        w_state_nxt = (L_JV_NXT == 10'd0) ? S_FALL : S_RISE;
      end
    end else if (r_frame_tick) begin
      case (r_state)
        S_RISE: begin
          if (w_y11 < (L_TOP + {1'b0, r_v})) begin
            w_y_nxt     = L_TOP10;
            w_v_nxt     = '0;
            w_state_nxt = S_FALL;
          end else begin
            w_y_nxt     = 10'(w_y11 - {1'b0, r_v});
            w_v_nxt     = w_vdec;
            w_state_nxt = (w_vdec == 10'd0) ? S_FALL : S_RISE;
          end
        end
        S_FALL: begin
          if (w_ysum >= L_FLOOR) begin
            w_y_nxt     = L_FLOOR10;
            w_v_nxt     = '0;
            w_state_nxt = S_GROUND;
          end else begin
            w_y_nxt = 10'(w_ysum);
            w_v_nxt = w_vfall;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign currY      = {22'd0, r_y};
  assign state      = r_state;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized scoreboard bench: two controllers (open sky, and a tight top/floor box) share
// the button and vsync stimulus; a frame-level reference model predicts every post-tick row/state.
module tb_sprite_motion_ctrl;
  localparam int DEB = 4, JV = 3, GR = 1, MV = 10, SY = 200;
  localparam int TOP0 = 0,   FLR0 = 440;
  localparam int TOP1 = 196, FLR1 = 205;
  localparam int ST_IDLE = 0, ST_RISE = 1, ST_FALL = 2, ST_GND = 3;

  typedef struct {int y; int s;} exp_t;

  logic        clk = 1'b0;
  logic        reset, boton, vsync;
  logic [31:0] y0, y1;
  logic [1:0]  s0, s1;
  logic        t0, t1;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.START_Y(SY), .TOP_Y(TOP0), .FLOOR_Y(FLR0), .JUMP_V(JV), .GRAVITY(GR),
    .MAX_V(MV), .DEBOUNCE_CYCLES(DEB)) u_dut0 (
    .clk(clk), .reset(reset), .boton(boton), .vsync(vsync),
    .currY(y0), .state(s0), .frame_tick(t0));

  sprite_motion_ctrl #(.START_Y(SY), .TOP_Y(TOP1), .FLOOR_Y(FLR1), .JUMP_V(JV), .GRAVITY(GR),
    .MAX_V(MV), .DEBOUNCE_CYCLES(DEB)) u_dut1 (
    .clk(clk), .reset(reset), .boton(boton), .vsync(vsync),
    .currY(y1), .state(s1), .frame_tick(t1));

  int   n_chk = 0, n_fail = 0;
  exp_t q0[$], q1[$];
  int   my[2], mv[2], mst[2], mtop[2], mflr[2];
  bit   pend, db;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      my[d] = SY; mv[d] = 0; mst[d] = ST_IDLE;
    end
    pend = 0; db = 0;
  endtask

  // One frame of motion, straight from the jump/rise/fall/clamp rules
  task automatic model_step(input int d, input bit jmp);
    int y, v, st;
    y = my[d]; v = mv[d]; st = mst[d];
    if (jmp) begin
      if (y - JV < mtop[d]) begin y = mtop[d]; v = 0; st = ST_FALL; end
      else begin
        y  = y - JV;
        v  = (JV - GR > 0) ? JV - GR : 0;
        st = (v == 0) ? ST_FALL : ST_RISE;
      end
    end else if (st == ST_RISE) begin
      if (y - v < mtop[d]) begin y = mtop[d]; v = 0; st = ST_FALL; end
      else begin
        y = y - v;
        v = (v - GR > 0) ? v - GR : 0;
        if (v == 0) st = ST_FALL;
      end
    end else if (st == ST_FALL) begin
      v = (v + GR > MV) ? MV : v + GR;
      if (y + v >= mflr[d]) begin y = mflr[d]; v = 0; st = ST_GND; end
      else y = y + v;
    end
    my[d] = y; mv[d] = v; mst[d] = st;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // kind 0: idle frame, 1: set button level to len, 2: pulse away from the current level for len cycles
  task automatic do_frame(input int kind, input int len);
    bit   rise, lvl;
    exp_t e;
    rise = 0;
    if (kind == 1) begin
      lvl = (len != 0);
      if (!db && lvl) rise = 1;
      db = lvl; boton = lvl;
    end else if (kind == 2) begin
      boton = ~db;
      cyc(len);
      boton = db;
      if (len >= DEB) rise = 1;
    end
    cyc(12);
    pend = pend | rise;
    for (int d = 0; d < 2; d++) begin
      model_step(d, pend);
      e.y = my[d]; e.s = mst[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    pend = 0;
    vsync = 1'b0;
    cyc(4);
    vsync = 1'b1;
    cyc(4);
  endtask

  task automatic cmp_out(input int d, input int y, input int s);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_tick dut%0d: got a frame update, expected none (t=%0t)", d, $time);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("currY dut%0d", d), y, e.y);
      check($sformatf("state dut%0d", d), s, e.s);
    end
  endtask

  // Monitors: the row/state are compared one cycle after each observed frame_tick
  initial begin
    bit armed;
    armed = 0;
    forever begin
      @(negedge clk);
      if (armed) cmp_out(0, int'(y0), int'(s0));
      armed = t0;
    end
  end

  initial begin
    bit armed;
    armed = 0;
    forever begin
      @(negedge clk);
      if (armed) cmp_out(1, int'(y1), int'(s1));
      armed = t1;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " currY0"}, int'(y0), SY);
    check({tag, " state0"}, int'(s0), ST_IDLE);
    check({tag, " tick0"},  int'(t0), 0);
    check({tag, " currY1"}, int'(y1), SY);
    check({tag, " state1"}, int'(s1), ST_IDLE);
  endtask

  // Async reset in mid-cycle while moving; released with vsync low, so no tick may follow
  task automatic midflight_reset();
    boton = 1'b0;
    cyc(1);
    #1 reset = 1'b0; vsync = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    cyc(3);
    reset = 1'b1;
    cyc(10);
    vsync = 1'b1;
    cyc(6);
    check_reset_outputs("after_release");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    mtop[0] = TOP0; mflr[0] = FLR0;
    mtop[1] = TOP1; mflr[1] = FLR1;
    model_reset();
    reset = 1'b0; boton = 1'b0; vsync = 1'b1;
    cyc(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    cyc(5);

    repeat (5) do_frame(0, 0);          // idle: row stays at start
    do_frame(2, 3);                      // glitch shorter than debounce
    repeat (3) do_frame(0, 0);
    do_frame(2, 6);                      // accepted press: jump arc / top clamp
    repeat (8) do_frame(0, 0);
    do_frame(1, 1);                      // held button: one jump only
    repeat (10) do_frame(0, 0);
    do_frame(1, 0);
    do_frame(1, 1);                      // re-press: second jump
    repeat (4) do_frame(0, 0);
    do_frame(1, 0);
    do_frame(2, 6);
    do_frame(0, 0);
    midflight_reset();
    repeat (5) do_frame(0, 0);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5)      do_frame(0, 0);
      else if (k < 8) do_frame(2, $urandom_range(1, 8));
      else            do_frame(1, $urandom_range(0, 1));
      if (i == 75) begin
        midflight_reset();
      end
    end

    cyc(5);
    check("pending expectations dut0", q0.size(), 0);
    check("pending expectations dut1", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
